// File: rtl/fetch_unit.sv
// fetch_unit: PC register, combinational imem port and a small {pc, instr} FIFO toward decode.
// A branch redirect reloads the PC and empties the FIFO in the same edge.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pcplus8
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [31:0]   pcs_q   [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic          pop, push;

    assign imem_a      = pc_q;
    assign out_valid   = cnt_q != '0;
    assign out_instr   = instr_q[rd_q];
    assign out_pc      = pcs_q[rd_q];
    assign out_pcplus8 = out_pc + 32'd8;

    // A redirect voids any handshake happening in the same cycle
    assign pop  = out_valid & out_ready & ~redirect;
    assign push = fetch_en & ~redirect & ((cnt_q < FULL) | pop);

    always_comb begin
        pc_d  = redirect ? {redirect_pc[31:2], 2'b00} : push ? pc_q + 32'd4 : pc_q;
        wr_d  = redirect ? '0 : push ? wr_q + 1'b1 : wr_q;
        rd_d  = redirect ? '0 : pop ? rd_q + 1'b1 : rd_q;
        cnt_d = redirect ? '0 : (push & ~pop) ? cnt_q + 1'b1 : (pop & ~push) ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= {RESET_PC[31:2], 2'b00};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pcs_q[i]   <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (push) begin
                pcs_q[wr_q]   <= pc_q;
                instr_q[wr_q] <= imem_rd;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic against a queue-based fetch model.
module tb_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_a, imem_rd, out_instr, out_pc, out_pcplus8;
    logic        out_valid;

    typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
    ent_t        q[$];
    logic [31:0] mpc = '0;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a == 32'd0 ? 32'hE3A0_0001 : a == 32'd4 ? 32'hE3A0_1002 : (a * 32'h9E37_79B1) ^ 32'hE3A0_0000;
    endfunction

    assign imem_rd = mem(imem_a);

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_a(imem_a), .imem_rd(imem_rd),
        .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .out_pcplus8(out_pcplus8)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model across the edge, return #1 after it
    task automatic tick(input logic en, input logic rdy, input logic rdr, input logic [31:0] rpc);
        logic pop, push;
        ent_t e;
        fetch_en = en; out_ready = rdy; redirect = rdr; redirect_pc = rpc;
        if (rdr) begin
            q.delete();
            mpc = rpc & ~32'd3;
        end else begin
            pop  = q.size() != 0 && rdy;
            push = en && (q.size() < DEPTH || pop);
            if (pop) void'(q.pop_front());
            if (push) begin
                e.pc = mpc; e.instr = mem(mpc);
                q.push_back(e);
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        fetch_en = 0; out_ready = 0; redirect = 0;
        reset = 0; #2;
        q.delete(); mpc = '0;
        reset = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #3;
        n_chk += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        if (imem_a !== 32'h0) begin n_fail++; $display("FAIL reset_imem_a got=%h exp=0", imem_a); end
        if (out_pcplus8 !== 32'h8) begin n_fail++; $display("FAIL reset_pcplus8 got=%h exp=8", out_pcplus8); end
        if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
        @(posedge clk); #1;
        reset = 1;
        tick(0, 0, 0, 0);
        n_chk += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL en0_valid got=%b exp=0", out_valid); end
        if (imem_a !== 32'h0) begin n_fail++; $display("FAIL en0_imem_a got=%h exp=0", imem_a); end
    endtask

    task automatic test_stream();
        tick(1, 1, 0, 0);
        n_chk += 2;
        if (out_pc !== 32'h0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_pc0 got=%h/%b exp=0/1", out_pc, out_valid); end
        if (out_instr !== 32'hE3A0_0001) begin n_fail++; $display("FAIL stream_instr0 got=%h exp=e3a00001", out_instr); end
        tick(1, 1, 0, 0);
        n_chk += 2;
        if (out_pc !== 32'h4) begin n_fail++; $display("FAIL stream_pc1 got=%h exp=4", out_pc); end
        if (out_instr !== 32'hE3A0_1002) begin n_fail++; $display("FAIL stream_instr1 got=%h exp=e3a01002", out_instr); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        do_reset();
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        n_chk += 2;
        if (imem_a !== 32'h8) begin n_fail++; $display("FAIL full_hold_imem_a got=%h exp=8", imem_a); end
        if (out_pc !== 32'h0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL full_head got=%h exp=0", out_pc); end
        for (int i = 1; i <= 3; i++) begin
            tick(1, 1, 0, 0);
            exp_pc = 32'(i * 4);
            n_chk++;
            if (out_pc !== exp_pc || out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_pc%0d got=%h exp=%h", i, out_pc, exp_pc); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(1, 1, 1, 32'h40);
        n_chk += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid got=%b exp=0", out_valid); end
        if (imem_a !== 32'h40) begin n_fail++; $display("FAIL redir_imem_a got=%h exp=40", imem_a); end
        tick(1, 0, 0, 0);
        n_chk += 2;
        if (out_pc !== 32'h40 || out_valid !== 1'b1) begin n_fail++; $display("FAIL redir_head got=%h exp=40", out_pc); end
        if (out_instr !== mem(32'h40)) begin n_fail++; $display("FAIL redir_instr got=%h exp=%h", out_instr, mem(32'h40)); end
    endtask

    task automatic test_wrap();
        tick(1, 0, 1, 32'h43);
        n_chk++;
        if (imem_a !== 32'h40) begin n_fail++; $display("FAIL align_imem_a got=%h exp=40", imem_a); end
        tick(0, 1, 1, 32'hFFFF_FFFC);
        tick(1, 0, 0, 0);
        n_chk += 3;
        if (out_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc got=%h exp=fffffffc", out_pc); end
        if (out_pcplus8 !== 32'h4) begin n_fail++; $display("FAIL wrap_pcplus8 got=%h exp=4", out_pcplus8); end
        if (imem_a !== 32'h0) begin n_fail++; $display("FAIL wrap_imem_a got=%h exp=0", imem_a); end
        tick(1, 1, 0, 0);
        n_chk++;
        if (out_pc !== 32'h0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_next got=%h exp=0", out_pc); end
    endtask

    task automatic test_async_reset();
        tick(1, 1, 0, 32'h100);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        #2 reset = 0;
        #1;
        n_chk += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid got=%b exp=0", out_valid); end
        if (imem_a !== 32'h0) begin n_fail++; $display("FAIL async_imem_a got=%h exp=0", imem_a); end
        q.delete(); mpc = '0;
        @(posedge clk); #1;
        reset = 1;
        tick(1, 0, 0, 0);
        n_chk++;
        if (out_pc !== 32'h0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL async_resume got=%h exp=0", out_pc); end
    endtask

    task automatic test_random();
        logic ev;
        for (int c = 0; c < 400; c++) begin
            tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0), $urandom);
            ev = q.size() != 0;
            n_chk += 2;
            if (out_valid !== ev) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, ev); end
            if (imem_a !== mpc) begin n_fail++; $display("FAIL rnd_imem_a c=%0d got=%h exp=%h", c, imem_a, mpc); end
            if (ev) begin
                n_chk += 3;
                if (out_pc !== q[0].pc) begin n_fail++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, out_pc, q[0].pc); end
                if (out_instr !== q[0].instr) begin n_fail++; $display("FAIL rnd_instr c=%0d got=%h exp=%h", c, out_instr, q[0].instr); end
                if (out_pcplus8 !== q[0].pc + 32'd8) begin n_fail++; $display("FAIL rnd_pcplus8 c=%0d got=%h exp=%h", c, out_pcplus8, q[0].pc + 32'd8); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
